// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM generator: default count width and FSM encoding.
package pwm_gen_pkg;

    // Default bit width of the upstream free-running count.
    localparam int DEFAULT_WIDTH = 4;

    // Output-stage state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_gen_wrap_detect.sv
// Wrap detector: remembers last cycle's count and flags a wrap whenever the
// count goes down. A stalled or increasing count is never a wrap.
// The raw (combinational) wrap feeds the parent's update logic; the
// registered pulse is the externally visible period_start.
module wrap_detect
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             period_start
);

    logic [WIDTH-1:0] prev_count_r;
    logic             period_start_r;
    logic             wrap_s;

    // A strict unsigned decrease of the count marks the start of a new period.
    always_comb begin
        wrap_s = 1'b0;
        if (count < prev_count_r) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Track previous count and emit a one-cycle pulse after each wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count_r   <= {WIDTH{1'b0}};
            period_start_r <= 1'b0;
        end else begin
            prev_count_r   <= count;
            period_start_r <= wrap_s;
        end
    end

    assign wrap         = wrap_s;
    assign period_start = period_start_r;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator driven by an external free-running counter.
// A duty request is captured into a shadow (pending) register and only takes
// effect at the next count wrap, so each period is generated with one
// consistent duty value. The output stage waits for a wrap after enable so
// the first driven period is always a complete one.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic [WIDTH:0]   duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm,
    output logic             period_start,
    output logic             pending
);

    // Full-scale duty: high for every tick of the period.
    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    // Limit a requested duty to full scale.
    function automatic logic [WIDTH:0] clamp_duty(input logic [WIDTH:0] d);
        logic [WIDTH:0] r;
        if (d > DUTY_MAX) begin
            r = DUTY_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    pwm_state_t     state_r;
    logic [WIDTH:0] active_r;
    logic [WIDTH:0] pending_duty_r;
    logic           pending_valid_r;
    logic           pwm_r;

    logic           wrap_s;
    logic           period_start_s;
    logic           capture_s;
    logic           load_s;
    logic [WIDTH:0] duty_clamped_s;
    logic [WIDTH:0] active_eff_s;
    logic           cmp_s;

    wrap_detect #(
        .WIDTH        (WIDTH)
    ) u_wrap_detect (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .wrap         (wrap_s),
        .period_start (period_start_s)
    );

    // Handshake, shadow-to-active transfer and the compare for this cycle.
    // On a wrap with a pending value, the new duty already governs the
    // count value that starts the new period.
    always_comb begin
        capture_s      = 1'b0;
        load_s         = 1'b0;
        active_eff_s   = active_r;
        cmp_s          = 1'b0;
        duty_clamped_s = clamp_duty(duty);

        if (duty_valid && !pending_valid_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end

        if (wrap_s && pending_valid_r) begin
            load_s       = 1'b1;
            active_eff_s = pending_duty_r;
        end else begin
            load_s       = 1'b0;
            active_eff_s = active_r;
        end

        if ({1'b0, count} < active_eff_s) begin
            cmp_s = 1'b1;
        end else begin
            cmp_s = 1'b0;
        end
    end

    // Duty storage: a wrap promotes pending to active; otherwise an accepted
    // request fills the shadow. Both cannot happen in one cycle because a
    // request is only accepted while the shadow is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r        <= {(WIDTH+1){1'b0}};
            pending_duty_r  <= {(WIDTH+1){1'b0}};
            pending_valid_r <= 1'b0;
        end else if (load_s) begin
            active_r        <= pending_duty_r;
            pending_valid_r <= 1'b0;
        end else if (capture_s) begin
            pending_duty_r  <= duty_clamped_s;
            pending_valid_r <= 1'b1;
        end else begin
            active_r        <= active_r;
            pending_duty_r  <= pending_duty_r;
            pending_valid_r <= pending_valid_r;
        end
    end

    // Output FSM: idle until enabled, sync to the next wrap, then drive the
    // registered compare. Dropping enable returns to idle from any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            pwm_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pwm_r <= 1'b0;
                    if (en) begin
                        state_r <= ST_SYNC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                        pwm_r   <= 1'b0;
                    end else if (wrap_s) begin
                        state_r <= ST_RUN;
                        pwm_r   <= cmp_s;
                    end else begin
                        state_r <= ST_SYNC;
                        pwm_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                        pwm_r   <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        pwm_r   <= cmp_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pwm_r   <= 1'b0;
                end
            endcase
        end
    end

    assign duty_ready   = ~pending_valid_r;
    assign pending      = pending_valid_r;
    assign pwm          = pwm_r;
    assign period_start = period_start_s;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen. Each step drives count/en/duty just after a
// rising edge and checks the registered outputs 1 time unit after the next
// rising edge, so pwm after a step reflects (applied count < duty in effect).
module tb_pwm_gen;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   count;
    logic           en;
    logic [W:0]     duty;
    logic           duty_valid;
    logic           duty_ready;
    logic           pwm;
    logic           period_start;
    logic           pending;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic rst;
        logic en;
        int   cnt;
        int   duty;
        logic dv;
        logic e_pwm;
        logic e_ps;
        logic e_pend;
    } vec_t;

    vec_t tbl[14];

    pwm_gen #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .en           (en),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm          (pwm),
        .period_start (period_start),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ep, input logic eps, input logic epd);
        chk({tag, " pwm"}, pwm, ep);
        chk({tag, " period_start"}, period_start, eps);
        chk({tag, " pending"}, pending, epd);
        chk({tag, " duty_ready"}, duty_ready, ~epd);
    endtask

    task automatic step(input int c, input logic e, input int d, input logic dv);
        count      = c[W-1:0];
        en         = e;
        duty       = d[W:0];
        duty_valid = dv;
        @(posedge clk);
        #1;
    endtask

    // One full 0..15 period (count 0 is the wrap) with duty d in effect,
    // optionally offering ov at count oc (oc=16 means no offer).
    task automatic period(input string tag, input int d, input int oc, input int ov);
        for (int c = 0; c < 16; c++) begin
            step(c, 1'b1, ov, (c == oc));
            check_all($sformatf("%s c=%0d", tag, c), (c < d), (c == 0), (c >= oc));
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; count = 4'd0; duty = 5'd0; duty_valid = 1'b0;

        //            rst   en    cnt dut dv    pwm   ps    pend
        tbl[0]  = '{1'b0, 1'b0,  3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1,  4, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0,  5, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1,  6, 8, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1,  7, 3, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1,  8, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 15, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1,  0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1,  7, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1,  8, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1,  8, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1,  0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset, release, enable with duty 8, sync to wrap, first period.
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            step(tbl[i].cnt, tbl[i].en, tbl[i].duty, tbl[i].dv);
            check_all($sformatf("vec%0d", i), tbl[i].e_pwm, tbl[i].e_ps, tbl[i].e_pend);
        end

        for (int c = 1; c < 16; c++) begin
            step(c, 1'b1, 0, 1'b0);
            check_all($sformatf("p8a c=%0d", c), (c < 8), 1'b0, 1'b0);
        end
        period("p8", 8, 16, 0);

        // Duty change is deferred to the wrap.
        period("p8_offer4", 8, 1, 4);
        period("p4_offer12", 4, 7, 12);
        period("p12", 12, 16, 0);

        // Extremes and clamping.
        period("p12_offer0", 12, 2, 0);
        period("p0", 0, 16, 0);
        period("p0_offer16", 0, 2, 16);
        period("p16", 16, 16, 0);
        period("p16_offer31", 16, 2, 31);
        period("p16_clamped", 16, 16, 0);
        period("p16_offer5", 16, 2, 5);

        // Count stall at 9, then 9->3 jump applies pending duty 2.
        step(0, 1'b1, 0, 1'b0);
        check_all("stall wrap0", 1'b1, 1'b1, 1'b0);
        step(9, 1'b1, 2, 1'b1);
        check_all("stall c9 offer", 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(9, 1'b1, 2, 1'b0);
            check_all($sformatf("stall hold%0d", k), 1'b0, 1'b0, 1'b1);
        end
        step(3, 1'b1, 0, 1'b0);
        check_all("jump 9to3", 1'b0, 1'b1, 1'b0);
        for (int c = 4; c < 16; c++) begin
            step(c, 1'b1, 0, 1'b0);
            check_all($sformatf("p2a c=%0d", c), (c < 2), 1'b0, 1'b0);
        end

        // Offer on the wrap cycle itself: captured, applies one period later.
        period("p2_offer9_at_wrap", 2, 0, 9);
        period("p9", 9, 16, 0);

        // Reset mid-period with a pending duty.
        for (int c = 0; c < 4; c++) begin
            step(c, 1'b1, 0, 1'b0);
            check_all($sformatf("pre_rst c=%0d", c), (c < 9), (c == 0), 1'b0);
        end
        step(4, 1'b1, 3, 1'b1);
        check_all("pre_rst offer", 1'b1, 1'b0, 1'b1);
        step(5, 1'b1, 0, 1'b0);
        check_all("pre_rst c=5", 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_all("rst_immediate", 1'b0, 1'b0, 1'b0);
        step(6, 1'b1, 0, 1'b0);
        check_all("rst_hold1", 1'b0, 1'b0, 1'b0);
        step(7, 1'b1, 0, 1'b0);
        check_all("rst_hold2", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(8, 1'b1, 0, 1'b0);
        check_all("post_rst c=8", 1'b0, 1'b0, 1'b0);
        step(10, 1'b1, 6, 1'b1);
        check_all("post_rst offer6", 1'b0, 1'b0, 1'b1);
        step(15, 1'b1, 0, 1'b0);
        check_all("post_rst c=15", 1'b0, 1'b0, 1'b1);
        step(0, 1'b1, 0, 1'b0);
        check_all("post_rst wrap", 1'b1, 1'b1, 1'b0);

        // Enable drop forces pwm low; re-enable waits for a wrap, active kept.
        step(1, 1'b1, 0, 1'b0);
        check_all("en c=1", 1'b1, 1'b0, 1'b0);
        step(2, 1'b1, 0, 1'b0);
        check_all("en c=2", 1'b1, 1'b0, 1'b0);
        step(3, 1'b0, 0, 1'b0);
        check_all("en_off c=3", 1'b0, 1'b0, 1'b0);
        step(4, 1'b0, 0, 1'b0);
        check_all("en_off c=4", 1'b0, 1'b0, 1'b0);
        for (int c = 5; c < 16; c++) begin
            step(c, 1'b1, 0, 1'b0);
            check_all($sformatf("resync c=%0d", c), 1'b0, 1'b0, 1'b0);
        end
        period("p6_after_resync", 6, 16, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the count input.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port count, input, WIDTH bits: free-running count from the upstream counter, synchronous to clk.
REQ-005 SHALL have port en, input, 1 bit: PWM enable.
REQ-006 SHALL have port duty, input, WIDTH+1 bits: requested high-time in count ticks, 0..2^WIDTH.
REQ-007 SHALL have port duty_valid, input, 1 bit: duty is offered this cycle.
REQ-008 SHALL have port duty_ready, output, 1 bit: block can accept a duty value.
REQ-009 SHALL have port pwm, output, 1 bit: registered PWM waveform.
REQ-010 SHALL have port period_start, output, 1 bit: one-cycle pulse on each detected count wrap.
REQ-011 SHALL have port pending, output, 1 bit: a captured duty awaits the next wrap.

Function
REQ-012 SHALL register count into prev_count every cycle.
REQ-013 SHALL detect a wrap when count < prev_count (unsigned); an unchanged count (stall) or an increase SHALL NOT be a wrap.
REQ-014 SHALL drive period_start high for exactly the cycle after the wrap is detected, independent of en.
REQ-015 SHALL hold an active duty register and a pending (shadow) register with a valid flag.
REQ-016 SHALL drive duty_ready = NOT pending, combinationally.
REQ-017 SHALL capture duty into pending on duty_valid AND duty_ready; duty values above 2^WIDTH SHALL be clamped to 2^WIDTH.
REQ-018 SHALL, on a detected wrap with pending set, copy pending to active and clear pending in the same edge.
REQ-019 SHALL, when capture and wrap coincide with pending clear, store the new value as pending; it SHALL NOT apply until the following wrap.
REQ-020 SHALL implement states IDLE, SYNC, RUN.
REQ-021 IDLE -> SYNC when en=1; SYNC -> RUN on a detected wrap; any state -> IDLE when en=0.
REQ-022 SHALL drive pwm=0 in IDLE and SYNC; in RUN, pwm SHALL be registered (count < active) with one-cycle latency, using the active value in effect for that cycle.
REQ-023 duty=0 SHALL yield pwm constantly 0; duty=2^WIDTH SHALL yield pwm constantly 1 while in RUN.
REQ-024 Deasserting en SHALL force pwm=0 on the next edge; pending and active SHALL be retained.

Reset
REQ-025 While rst=0: state=IDLE, pwm=0, period_start=0, pending=0, active=0, prev_count=0; duty_ready therefore reads 1.
REQ-026 Reset asserted mid-period SHALL discard any pending duty; after release, the block SHALL re-enter SYNC only through en=1 and SHALL wait for a wrap before driving pwm.

Structure
REQ-027 State encoding (IDLE/SYNC/RUN) and the default WIDTH SHALL live in a shared package.
REQ-028 Wrap detection SHALL be one sub-module, wrap_detect (prev_count register, compare, period_start pulse); all other logic SHALL be in pwm_gen.

Verification
REQ-029 Reset with count running, release, en=1, duty=8 offered -> pwm stays 0 until first 15->0 wrap; then high 8 clk, low 8 clk per 16-count period.
REQ-030 In RUN with active=4, offer duty=12 at count=7 -> pending=1, duty_ready=0 until wrap; waveform switches to 12 high ticks only after wrap; pending clears.
REQ-031 duty=0 then duty=16 (and duty=31 clamped to 16) -> pwm constantly 0, then constantly 1 across periods.
REQ-032 Hold count at 9 for 5 cycles -> no period_start, pwm constant; count 9->3 jump -> period_start one cycle, pending applied.
REQ-033 duty_valid asserted on wrap cycle with pending clear -> value captured as pending, applied on next wrap, not current.
REQ-034 rst=0 for 2 cycles mid-period with pending set -> all outputs 0 at once, pending cleared, duty_ready=1; after release, en=1 waits for wrap.
